renkon_conv_ctrl: RTL

//  Sequencer for the 5x5 convolution tree (25 products, 5-stage pipeline) in the renkon conv layer.
//  Per request it loops output channel -> input channel -> output pixel:
//    - loads 25 weights for each (och, ich) pair;
//    - sweeps every 5x5 window of the input map, one window per cycle.
//  It emits the operand-valid, accumulate and writeback strobes, each aligned to the tree's output latency.
//  It sits between the layer-level command (req/ack, from the top controller) and the

---
 rtl/renkon_conv_ctrl_pkg.sv | 41 ++++
 rtl/renkon_ctrl_delay.sv | 48 ++++
 rtl/renkon_conv_ctrl.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/renkon_conv_ctrl_pkg.sv
// renkon_conv_ctrl_pkg
//   Shared widths, latencies and types for the renkon conv-layer sequencer
//   and its helpers (delay line, later the pool/linear controllers).
//   Contents:
//     CWIDTH   channel count/index width
//     MWIDTH   map edge width
//     AWIDTH   output/weight address width (>= 2*MWIDTH)
//     LWIDTH   fixed-point shift width
//     CONV_LAT conv tree latency, operands in -> fmap out
//     FSIZE    filter edge of the 5x5 tree
//     ctrl_state_t  sequencer states
//     fmap_tag_t    sideband carried alongside each window through the tree
package renkon_conv_ctrl_pkg;

  localparam int CWIDTH   = 8;
  localparam int MWIDTH   = 8;
  localparam int AWIDTH   = 20;
  localparam int LWIDTH   = 5;
  localparam int CONV_LAT = 5;
  localparam int FSIZE    = 5;
  localparam int TAPS     = FSIZE * FSIZE;
  localparam int TAP_W    = $clog2(TAPS);
  localparam int DRAIN_W  = $clog2(CONV_LAT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WLOAD,
    S_CONV,
    S_DRAIN,
    S_DONE
  } ctrl_state_t;

  // Travels through the delay line so the accumulator strobes line up
  // with the fmap the tree produces for that window.
  typedef struct packed {
    logic              first_ich;
    logic              last_ich;
    logic [AWIDTH-1:0] addr;
  } fmap_tag_t;

endpackage

// File: rtl/renkon_ctrl_delay.sv
// renkon_ctrl_delay
//   Fixed-depth valid+payload shift register used to line control strobes
//   up with a fixed-latency datapath. Shifts every cycle regardless of
//   controller state; rst and clr both empty it synchronously.
//   Ports:
//     clk        clock
//     rst        synchronous active-high reset
//     clr        synchronous flush
//     in_valid   entry valid at stage 0 input
//     in_data    entry payload
//     out_valid  valid leaving the last stage (DEPTH cycles after in_valid)
//     out_data   payload leaving the last stage
//   DEPTH must be at least 2.
module renkon_ctrl_delay
  import renkon_conv_ctrl_pkg::*;
#(
  parameter int DEPTH = CONV_LAT,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);

  logic [DEPTH-1:0] vld;
  logic [WIDTH-1:0] dat [DEPTH];

  // Plain shift: stage i takes stage i-1 every cycle. Payload is cleared
  // along with valid so a flushed line never leaks stale addresses.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      vld <= '0;
      for (int i = 0; i < DEPTH; i++) dat[i] <= '0;
    end else begin
      vld    <= {vld[DEPTH-2:0], in_valid};
      dat[0] <= in_data;
      for (int i = 1; i < DEPTH; i++) dat[i] <= dat[i-1];
    end
  end

  assign out_valid = vld[DEPTH-1];
  assign out_data  = dat[DEPTH-1];

endmodule

// File: rtl/renkon_conv_ctrl.sv
// renkon_conv_ctrl
//   Sequencer for the 5x5 convolution tree. For each accepted request it
//   walks output channel -> input channel, loading 25 weights per pair and
//   then sweeping every 5x5 window of the input map (one per cycle). The
//   accumulator/writeback strobes are delayed by the tree latency so they
//   arrive with the matching fmap.
//   Ports:
//     clk, rst        clock, synchronous active-high reset
//     req             start pulse, honoured only when idle and not acking
//     _isize/_osize   input/output channel counts (latched on accept)
//     _fsize          input map edge (latched on accept)
//     _qbits/qbits    fixed-point shift in / latched copy for the tree
//     ack, busy       completion pulse / in-progress flag
//     w_we, w_addr    weight-load strobe and address
//     win_oe, win_row, win_col  window buffer enable and window origin
//     conv_oe         operands valid at tree input
//     acc_clr, acc_en accumulator load-vs-add and enable
//     out_we, out_addr  result writeback strobe and address
module renkon_conv_ctrl
  import renkon_conv_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic [CWIDTH-1:0] _isize,
  input  logic [CWIDTH-1:0] _osize,
  input  logic [MWIDTH-1:0] _fsize,
  input  logic [LWIDTH-1:0] _qbits,
  output logic [LWIDTH-1:0] qbits,
  output logic              ack,
  output logic              busy,
  output logic              w_we,
  output logic [AWIDTH-1:0] w_addr,
  output logic              win_oe,
  output logic [MWIDTH-1:0] win_row,
  output logic [MWIDTH-1:0] win_col,
  output logic              conv_oe,
  output logic              acc_clr,
  output logic              acc_en,
  output logic              out_we,
  output logic [AWIDTH-1:0] out_addr
);

  ctrl_state_t       state;
  logic [CWIDTH-1:0] isize_r;
  logic [CWIDTH-1:0] osize_r;
  logic [CWIDTH-1:0] ich;
  logic [CWIDTH-1:0] och;
  logic [MWIDTH-1:0] o_edge;
  logic [TAP_W-1:0]  tap;
  logic [DRAIN_W-1:0] drain_cnt;
  logic [AWIDTH-1:0] out_pos;
  logic [AWIDTH-1:0] och_base;

  logic start;
  logic cfg_bad;
  logic last_col;
  logic last_row;
  logic last_ich;
  logic last_och;

  fmap_tag_t               push_tag;
  fmap_tag_t               pop_tag;
  logic                    pop_valid;
  logic [$bits(fmap_tag_t)-1:0] pop_data;

  // A req landing in the ack cycle is dropped: state is already S_IDLE
  // there, so the ack flag itself masks it.
  assign start    = (state == S_IDLE) && req && !ack;
  assign cfg_bad  = (_isize == '0) || (_osize == '0) || (_fsize < MWIDTH'(FSIZE));
  assign last_col = (win_col == o_edge - MWIDTH'(1));
  assign last_row = (win_row == o_edge - MWIDTH'(1));
  assign last_ich = (ich == isize_r - CWIDTH'(1));
  assign last_och = (och == osize_r - CWIDTH'(1));

  // Sideband for the window currently on the tree input. Zeroed when no
  // window is issued so the delay line carries nothing meaningful then.
  always_comb begin
    push_tag = '0;
    if (conv_oe) begin
      push_tag.first_ich = (ich == '0);
      push_tag.last_ich  = last_ich;
      push_tag.addr      = out_pos;
    end
  end

  // Main sequencer. Outputs are registered: each branch sets the strobes
  // for the cycle the FSM is moving into. Weight address is one running
  // counter because (och, ich) pairs are visited in address order; the
  // output address restarts at the channel base each input-channel pass
  // and the base advances by simply continuing from the last window.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      isize_r   <= '0;
      osize_r   <= '0;
      o_edge    <= '0;
      qbits     <= '0;
      ich       <= '0;
      och       <= '0;
      tap       <= '0;
      drain_cnt <= '0;
      out_pos   <= '0;
      och_base  <= '0;
      ack       <= 1'b0;
      busy      <= 1'b0;
      w_we      <= 1'b0;
      w_addr    <= '0;
      win_oe    <= 1'b0;
      conv_oe   <= 1'b0;
      win_row   <= '0;
      win_col   <= '0;
    end else begin
      ack     <= 1'b0;
      w_we    <= 1'b0;
      win_oe  <= 1'b0;
      conv_oe <= 1'b0;
      case (state)
        S_IDLE: begin
          busy <= 1'b0;
          if (start) begin
            busy     <= 1'b1;
            isize_r  <= _isize;
            osize_r  <= _osize;
            o_edge   <= _fsize - MWIDTH'(FSIZE - 1);
            qbits    <= _qbits;
            ich      <= '0;
            och      <= '0;
            tap      <= '0;
            out_pos  <= '0;
            och_base <= '0;
            w_addr   <= '0;
            win_row  <= '0;
            win_col  <= '0;
            if (cfg_bad) begin
              state <= S_DONE;
            end else begin
              state <= S_WLOAD;
              w_we  <= 1'b1;
            end
          end
        end

        S_WLOAD: begin
          w_addr <= w_addr + AWIDTH'(1);
          if (tap == TAP_W'(TAPS - 1)) begin
            tap     <= '0;
            state   <= S_CONV;
            win_oe  <= 1'b1;
            conv_oe <= 1'b1;
          end else begin
            tap  <= tap + TAP_W'(1);
            w_we <= 1'b1;
          end
        end

        S_CONV: begin
          if (!(last_col && last_row)) begin
            win_oe  <= 1'b1;
            conv_oe <= 1'b1;
            out_pos <= out_pos + AWIDTH'(1);
            if (last_col) begin
              win_col <= '0;
              win_row <= win_row + MWIDTH'(1);
            end else begin
              win_col <= win_col + MWIDTH'(1);
            end
          end else begin
            win_row <= '0;
            win_col <= '0;
            if (!last_ich) begin
              ich     <= ich + CWIDTH'(1);
              out_pos <= och_base;
              state   <= S_WLOAD;
              w_we    <= 1'b1;
            end else begin
              ich <= '0;
              if (!last_och) begin
                och      <= och + CWIDTH'(1);
                och_base <= out_pos + AWIDTH'(1);
                out_pos  <= out_pos + AWIDTH'(1);
                state    <= S_WLOAD;
                w_we     <= 1'b1;
              end else begin
                drain_cnt <= '0;
                state     <= S_DRAIN;
              end
            end
          end
        end

        S_DRAIN: begin
          if (drain_cnt == DRAIN_W'(CONV_LAT - 1)) begin
            drain_cnt <= '0;
            state     <= S_DONE;
          end else begin
            drain_cnt <= drain_cnt + DRAIN_W'(1);
          end
        end

        S_DONE: begin
          ack   <= 1'b1;
          state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

  // The line is empty whenever the sequencer is idle, so flushing it there
  // costs nothing and guards against any leftover entry.
  renkon_ctrl_delay #(
    .DEPTH (CONV_LAT),
    .WIDTH ($bits(fmap_tag_t))
  ) u_delay (
    .clk       (clk),
    .rst       (rst),
    .clr       (state == S_IDLE),
    .in_valid  (conv_oe),
    .in_data   (push_tag),
    .out_valid (pop_valid),
    .out_data  (pop_data)
  );

  assign pop_tag  = fmap_tag_t'(pop_data);
  assign acc_en   = pop_valid;
  assign acc_clr  = pop_valid & pop_tag.first_ich;
  assign out_we   = pop_valid & pop_tag.last_ich;
  assign out_addr = pop_tag.addr;

endmodule
